// File: rtl/block_encode_a20.sv
// (20,A) Reed-Muller block encoder for PUCCH UCI: A = 1..13 info bits in, 20 BPSK symbols out.
// Latency: first symbol valid the cycle after the A-th accepted input bit; one symbol per cycle.
// Backpressure: input is refused outside LOAD; output symbol, tlast held while m_axis_tready is low.
module block_encode_a20 #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  s_axis_aresetn,
    input  logic [3:0]            code_length,
    input  logic                  code_length_valid,
    input  logic                  s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  err
);

    // Soft-symbol levels: coded 0 -> +max, coded 1 -> -max (two's complement).
    localparam logic [DATA_WIDTH-1:0] SYM_POS = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] SYM_NEG = {1'b1, {(DATA_WIDTH-2){1'b0}}, 1'b1};

    localparam logic [3:0] MAX_LEN  = 4'd13;
    localparam logic [4:0] LAST_SYM = 5'd19;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t      state;
    logic [3:0]  a_len;
    logic [3:0]  bit_cnt;
    logic [19:0] cw;
    logic [4:0]  sym_idx;

    logic [19:0] cw_fold;
    logic        last_beat;
    logic [4:0]  nxt_idx;

    // Basis column n of the (20,A) code; bit i of the result is M[i][n].
    function automatic logic [19:0] col_of(input logic [3:0] n);
        logic [19:0] c;
        case (n)
            4'd0:    c = 20'hFFFFF;
            4'd1:    c = 20'h5A933;
            4'd2:    c = 20'h10E5A;
            4'd3:    c = 20'h6339C;
            4'd4:    c = 20'h7C3E0;
            4'd5:    c = 20'hFFC00;
            4'd6:    c = 20'hD8E64;
            4'd7:    c = 20'h4F5B0;
            4'd8:    c = 20'h218EC;
            4'd9:    c = 20'h1B746;
            4'd10:   c = 20'h0FFFF;
            4'd11:   c = 20'h33FFF;
            4'd12:   c = 20'h3FFFC;
            default: c = 20'h00000;
        endcase
        return c;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] sym_of(input logic b);
        return b ? SYM_NEG : SYM_POS;
    endfunction

    // Codeword after folding the current input bit, and frame-position helpers.
    always_comb begin
        cw_fold   = cw ^ (s_axis_tdata ? col_of(bit_cnt) : 20'd0);
        last_beat = (bit_cnt == (a_len - 4'd1));
        nxt_idx   = sym_idx + 5'd1;
    end

    // Frame FSM: length capture, bit accumulation, symbol emission; all outputs registered.
    always_ff @(posedge clk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            state         <= IDLE;
            a_len         <= 4'd0;
            bit_cnt       <= 4'd0;
            cw            <= 20'd0;
            sym_idx       <= 5'd0;
            s_axis_tready <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tdata  <= '0;
            err           <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (code_length_valid) begin
                        if ((code_length != 4'd0) && (code_length <= MAX_LEN)) begin
                            a_len         <= code_length;
                            cw            <= 20'd0;
                            bit_cnt       <= 4'd0;
                            s_axis_tready <= 1'b1;
                            state         <= LOAD;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (s_axis_tvalid && s_axis_tready) begin
                        cw      <= cw_fold;
                        bit_cnt <= bit_cnt + 4'd1;
                        // A misplaced tlast is flagged but the frame length stays A.
                        if (s_axis_tlast != last_beat) begin
                            err <= 1'b1;
                        end
                        if (last_beat) begin
                            s_axis_tready <= 1'b0;
                            m_axis_tvalid <= 1'b1;
                            m_axis_tdata  <= sym_of(cw_fold[0]);
                            m_axis_tlast  <= 1'b0;
                            sym_idx       <= 5'd0;
                            state         <= OUT;
                        end
                    end
                end
                OUT: begin
                    if (m_axis_tvalid && m_axis_tready) begin
                        if (sym_idx == LAST_SYM) begin
                            m_axis_tvalid <= 1'b0;
                            m_axis_tlast  <= 1'b0;
                            m_axis_tdata  <= '0;
                            state         <= IDLE;
                        end else begin
                            sym_idx      <= nxt_idx;
                            m_axis_tdata <= sym_of(cw[nxt_idx]);
                            m_axis_tlast <= (nxt_idx == LAST_SYM);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
